// File: rtl/ps2_keyboard_pkg.sv
// ps2_keyboard_pkg
// Shared constants and types for the PS/2 keyboard receiver.
//   PS2_EXT / PS2_BRK : scan-code prefix bytes (extended, break)
//   KEY_*             : game keycodes consumed by the datapath
//   rxState_e         : frame receiver state encoding
//   oddParity()       : 1 when a data+parity word carries an odd number of ones
package ps2_keyboard_pkg;

   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_BRK   = 8'hF0;
   localparam logic [7:0] KEY_ENTER = 8'h5A;
   localparam logic [7:0] KEY_RED   = 8'h1D;
   localparam logic [7:0] KEY_UP    = 8'h75;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rxState_e;

   function automatic logic oddParity(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// ps2_rx_frame
// Conditions the raw PS/2 lines and deserializes 11-bit frames.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   rx_byte[7:0]        : last deserialized data byte (stable after the stop bit)
//   byte_valid          : high in the stop-bit fall cycle of a good frame
//   frame_err           : high in the stop-bit fall cycle of a bad frame, or on timeout
// byte_valid and frame_err are combinational so that a single register stage in
// the parent lands its strobes one cycle after the stop-bit fall.
module ps2_rx_frame
   import ps2_keyboard_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    clkSync;
   logic [1:0]    dataSync;
   logic          filtLevel;
   logic [FW-1:0] filtCount;
   logic          fall;
   logic          sample;
   rxState_e      state;
   rxState_e      nextState;
   logic [2:0]    bitCount;
   logic [7:0]    shiftReg;
   logic          parityBit;
   logic [TW-1:0] toCount;
   logic          timeoutHit;

   // Two-flop synchronizers for both raw lines. They reset to the idle (high)
   // level so that leaving reset never looks like a clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         clkSync  <= 2'b11;
         dataSync <= 2'b11;
      end else begin
         clkSync  <= {clkSync[0], ps2_clk};
         dataSync <= {dataSync[0], ps2_data};
      end
   end

   // Glitch filter on the synchronized clock. filtCount tracks how many
   // consecutive samples have disagreed with the current filtered level; any
   // agreeing sample restarts the run, so short glitches never get through.
   always_ff @(posedge clk) begin
      if (reset) begin
         filtLevel <= 1'b1;
         filtCount <= '0;
      end else if (clkSync[1] == filtLevel) begin
         filtCount <= '0;
      end else if (filtCount == FILTER_LAST) begin
         filtLevel <= clkSync[1];
         filtCount <= '0;
      end else begin
         filtCount <= filtCount + 1'b1;
      end
   end

   assign fall       = filtLevel && !clkSync[1] && (filtCount == FILTER_LAST);
   assign sample     = dataSync[1];
   assign timeoutHit = (state != RX_IDLE) && !fall && (toCount == TIMEOUT_LAST);
   assign rx_byte    = shiftReg;

   // Inactivity watchdog: counts while a frame is in progress and restarts on
   // every filtered falling edge, so it only expires when the keyboard stalls.
   always_ff @(posedge clk) begin
      if (reset || state == RX_IDLE || fall) begin
         toCount <= '0;
      end else begin
         toCount <= toCount + 1'b1;
      end
   end

   // Frame state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RX_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state and frame verdict. The verdict is decided in the stop-bit fall
   // cycle; a timeout overrides everything and drops back to idle.
   always_comb begin
      nextState  = state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (fall && !sample) begin
               nextState = RX_DATA;
            end
         end
         RX_DATA: begin
            if (fall && bitCount == 3'd7) begin
               nextState = RX_PARITY;
            end
         end
         RX_PARITY: begin
            if (fall) begin
               nextState = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               nextState = RX_IDLE;
               if (sample && oddParity({shiftReg, parityBit})) begin
                  byte_valid = 1'b1;
               end else begin
                  frame_err = 1'b1;
               end
            end
         end
         default: nextState = RX_IDLE;
      endcase
      if (timeoutHit) begin
         nextState = RX_IDLE;
         frame_err = 1'b1;
      end
   end

   // Data capture: bits arrive LSB first, so each new sample enters at the top
   // of the shift register and the byte is aligned after the eighth bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         bitCount  <= '0;
         shiftReg  <= '0;
         parityBit <= 1'b0;
      end else if (fall) begin
         case (state)
            RX_IDLE: bitCount <= '0;
            RX_DATA: begin
               shiftReg <= {sample, shiftReg[7:1]};
               bitCount <= bitCount + 1'b1;
            end
            RX_PARITY: parityBit <= sample;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard
// PS/2 keyboard receiver: one qualified keycode event per key press or release.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   ps2_clk, ps2_data   : raw asynchronous PS/2 lines
//   keycode[7:0]        : last scan code with E0/F0 prefixes removed
//   make                : 1 = press, 0 = release (F0 preceded the code)
//   extended            : 1 = E0 preceded the code
//   keycode_ready       : one-cycle strobe, keycode/make/extended valid
//   err                 : one-cycle strobe on parity, framing or timeout error
module ps2_keyboard
   import ps2_keyboard_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       make,
   output logic       extended,
   output logic       keycode_ready,
   output logic       err
);

   logic [7:0] rxByte;
   logic       byteValid;
   logic       frameErr;
   logic       extFlag;
   logic       brkFlag;

   ps2_rx_frame #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .rx_byte   (rxByte),
      .byte_valid(byteValid),
      .frame_err (frameErr)
   );

   // Prefix decoding. E0 and F0 only arm flags; the first non-prefix byte
   // publishes a keycode event and consumes the flags. Any receive error
   // throws away a half-built prefix sequence so it cannot taint the next key.
   always_ff @(posedge clk) begin
      if (reset) begin
         keycode       <= '0;
         make          <= 1'b0;
         extended      <= 1'b0;
         keycode_ready <= 1'b0;
         err           <= 1'b0;
         extFlag       <= 1'b0;
         brkFlag       <= 1'b0;
      end else begin
         keycode_ready <= 1'b0;
         err           <= 1'b0;
         if (frameErr) begin
            err     <= 1'b1;
            extFlag <= 1'b0;
            brkFlag <= 1'b0;
         end else if (byteValid) begin
            if (rxByte == PS2_EXT) begin
               extFlag <= 1'b1;
            end else if (rxByte == PS2_BRK) begin
               brkFlag <= 1'b1;
            end else begin
               keycode       <= rxByte;
               make          <= ~brkFlag;
               extended      <= extFlag;
               keycode_ready <= 1'b1;
               extFlag       <= 1'b0;
               brkFlag       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard
// Directed bench for ps2_keyboard: drives PS/2 frames bit by bit and checks
// keycode events, error strobes, prefix handling, timeout, glitch rejection
// and mid-frame reset.
module tb_ps2_keyboard;
   import ps2_keyboard_pkg::*;

   localparam int HALF    = 200;
   localparam int TIMEOUT = 2000;
   // From driving ps2_clk low: 2 synchronizer edges, then FILTER_LEN (8) edges
   // until the frame logic acts on the fall, then TIMEOUT clk to the err register.
   localparam int TIMEOUT_LATENCY = 2 + 8 + TIMEOUT;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] keycode;
   logic       make;
   logic       extended;
   logic       keycode_ready;
   logic       err;

   int checks = 0;
   int errors = 0;
   int cycleCount = 0;
   int readyCount = 0;
   int errPulseCount = 0;
   int overlapCount = 0;
   int errCycle = 0;
   int lastFallDrive = 0;
   int readyBase = 0;
   int errBase = 0;

   ps2_keyboard #(
      .FILTER_LEN    (8),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clk      (ps2_clk),
      .ps2_data     (ps2_data),
      .keycode      (keycode),
      .make         (make),
      .extended     (extended),
      .keycode_ready(keycode_ready),
      .err          (err)
   );

   // 10 ns system clock.
   always #5 clk = ~clk;

   // Free-running cycle stamp used to time the timeout strobe.
   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Strobe monitor, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (keycode_ready) readyCount++;
      if (err) begin
         errPulseCount++;
         errCycle = cycleCount;
      end
      if (keycode_ready && err) overlapCount++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic markStrobes();
      readyBase = readyCount;
      errBase   = errPulseCount;
   endtask

   task automatic sendBit(input logic b, input bit glitch);
      ps2_data = b;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      lastFallDrive = cycleCount;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      if (glitch) begin
         repeat (50) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] data, input logic badParity,
                                input int glitchBit);
      sendBit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) sendBit(data[i], glitchBit == i);
      sendBit((~^data) ^ badParity, 1'b0);
      sendBit(1'b1, 1'b0);
      repeat (20) @(negedge clk);
   endtask

   task automatic sendPartial(input logic [7:0] data, input int nBits);
      sendBit(1'b0, 1'b0);
      for (int i = 0; i < nBits; i++) sendBit(data[i], 1'b0);
   endtask

   initial begin
      repeat (4) @(negedge clk);
      checkOutput("reset keycode", 32'(keycode), 32'h0);
      checkOutput("reset make", 32'(make), 32'h0);
      checkOutput("reset extended", 32'(extended), 32'h0);
      checkOutput("reset ready", 32'(keycode_ready), 32'h0);
      checkOutput("reset err", 32'(err), 32'h0);
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Plain make code.
      markStrobes();
      applyStimulus(KEY_RED, 1'b0, -1);
      checkOutput("t1 ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t1 keycode", 32'(keycode), 32'h1D);
      checkOutput("t1 make", 32'(make), 32'h1);
      checkOutput("t1 extended", 32'(extended), 32'h0);
      checkOutput("t1 err pulses", 32'(errPulseCount - errBase), 32'd0);

      // Break code: F0 alone is silent, then the released key.
      markStrobes();
      applyStimulus(PS2_BRK, 1'b0, -1);
      checkOutput("t2 no strobe after F0", 32'(readyCount - readyBase), 32'd0);
      applyStimulus(KEY_RED, 1'b0, -1);
      checkOutput("t2 ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t2 keycode", 32'(keycode), 32'h1D);
      checkOutput("t2 make", 32'(make), 32'h0);
      checkOutput("t2 extended", 32'(extended), 32'h0);

      // Extended break, then a plain make with flags cleared.
      markStrobes();
      applyStimulus(PS2_EXT, 1'b0, -1);
      applyStimulus(PS2_BRK, 1'b0, -1);
      applyStimulus(KEY_UP, 1'b0, -1);
      checkOutput("t3 ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t3 keycode", 32'(keycode), 32'h75);
      checkOutput("t3 make", 32'(make), 32'h0);
      checkOutput("t3 extended", 32'(extended), 32'h1);
      applyStimulus(KEY_ENTER, 1'b0, -1);
      checkOutput("t3b keycode", 32'(keycode), 32'h5A);
      checkOutput("t3b make", 32'(make), 32'h1);
      checkOutput("t3b extended", 32'(extended), 32'h0);

      // Parity error keeps the previous keycode.
      applyStimulus(KEY_RED, 1'b0, -1);
      markStrobes();
      applyStimulus(KEY_ENTER, 1'b1, -1);
      checkOutput("t4 err pulses", 32'(errPulseCount - errBase), 32'd1);
      checkOutput("t4 ready pulses", 32'(readyCount - readyBase), 32'd0);
      checkOutput("t4 keycode held", 32'(keycode), 32'h1D);
      markStrobes();
      applyStimulus(KEY_ENTER, 1'b0, -1);
      checkOutput("t4b ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t4b keycode", 32'(keycode), 32'h5A);
      checkOutput("t4b err pulses", 32'(errPulseCount - errBase), 32'd0);

      // Timeout after a stalled frame; an armed E0 must be discarded by it.
      applyStimulus(PS2_EXT, 1'b0, -1);
      markStrobes();
      sendPartial(KEY_RED, 4);
      repeat (TIMEOUT + 100) @(negedge clk);
      checkOutput("t5 err pulses", 32'(errPulseCount - errBase), 32'd1);
      checkOutput("t5 err latency", 32'(errCycle - lastFallDrive), 32'(TIMEOUT_LATENCY));
      checkOutput("t5 ready pulses", 32'(readyCount - readyBase), 32'd0);
      markStrobes();
      applyStimulus(KEY_RED, 1'b0, -1);
      checkOutput("t5b ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t5b keycode", 32'(keycode), 32'h1D);
      checkOutput("t5b make", 32'(make), 32'h1);
      checkOutput("t5b extended", 32'(extended), 32'h0);

      // Short low glitch on ps2_clk must not add a bit.
      markStrobes();
      applyStimulus(KEY_ENTER, 1'b0, 3);
      checkOutput("t6a ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t6a keycode", 32'(keycode), 32'h5A);
      checkOutput("t6a err pulses", 32'(errPulseCount - errBase), 32'd0);

      // Reset mid-frame: outputs cleared, no err, pending F0 forgotten.
      applyStimulus(PS2_BRK, 1'b0, -1);
      markStrobes();
      sendPartial(KEY_UP, 5);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("t6b keycode", 32'(keycode), 32'h0);
      checkOutput("t6b make", 32'(make), 32'h0);
      checkOutput("t6b extended", 32'(extended), 32'h0);
      checkOutput("t6b err pulses", 32'(errPulseCount - errBase), 32'd0);
      repeat (20) @(negedge clk);
      markStrobes();
      applyStimulus(KEY_UP, 1'b0, -1);
      checkOutput("t6c ready pulses", 32'(readyCount - readyBase), 32'd1);
      checkOutput("t6c keycode", 32'(keycode), 32'h75);
      checkOutput("t6c make", 32'(make), 32'h1);
      checkOutput("t6c extended", 32'(extended), 32'h0);

      checkOutput("ready/err overlap", 32'(overlapCount), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
Upstream PS/2 receiver that feeds the datapath's keyboard inputs (keycode, make, keycode_ready).
- Synchronizes and glitch-filters the raw ps2_clk/ps2_data lines from the keyboard.
- Deserializes 11-bit PS/2 frames and strips E0/F0 scan-code prefixes.
- Emits one qualified keycode event per physical key press or release, as a single-cycle strobe that the datapath and controller consume directly.

Parameters:
- FILTER_LEN, 8: number of consecutive identical synchronized ps2_clk samples needed to change the filtered clock level.
- TIMEOUT_CYCLES, 10000: clk cycles with no filtered falling edge, mid-frame, before the frame is aborted (200 us at 50 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock (asynchronous)
- ps2_data  in  1  raw PS/2 data (asynchronous)
- keycode  out  8  last decoded scan code (prefix bytes removed)
- make  out  1  1 = press, 0 = release (F0 seen) for keycode
- extended  out  1  1 = E0 prefix preceded keycode
- keycode_ready  out  1  one-cycle strobe: keycode/make/extended are valid
- err  out  1  one-cycle strobe on parity error, framing error or timeout

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high, named reset.
- With reset high at a rising edge, all outputs go to 0. The frame FSM goes to IDLE; bit counter, shift register, prefix flags, timeout counter and filter state clear (filtered clock level = 1).
- Reset asserted mid-frame discards the partial frame with no err pulse.

Input conditioning:
- ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- The filtered clock level changes only after FILTER_LEN consecutive identical synchronized samples.
- fall = one-cycle strobe on a filtered 1->0 transition. Synchronized ps2_data is sampled only in fall cycles.

Frame FSM (advances only on fall, except timeout):
- IDLE: sample 0 -> DATA, bit count 0. Sample 1 -> stay IDLE (false start, no err).
- DATA: shift the sample in LSB-first; after 8 samples -> PARITY.
- PARITY: store the sample -> STOP.
- STOP: return to IDLE on any sample.
  - Sample = 1 and odd parity (8 data bits + parity bit has an odd number of ones) -> byte valid.
  - Sample = 0 -> framing error. Parity mismatch -> parity error. Either error raises err.
- Timeout: in any state other than IDLE, a counter increments every clk and clears on fall. Reaching TIMEOUT_CYCLES -> IDLE and raise err.

Byte decode (on a valid byte):
- 8'hE0: set ext_flag; no strobe.
- 8'hF0: set brk_flag; no strobe.
- Any other byte:
  - keycode <= byte, make <= ~brk_flag, extended <= ext_flag.
  - keycode_ready high for exactly one clk; both flags clear.
- Any err event clears both flags.

Latency:
- keycode_ready and err assert in the clk cycle immediately after the cycle in which the stop-bit fall strobe (or the timeout terminal count) occurs.
- keycode, make and extended hold their values until the next keycode_ready.
- keycode_ready and err are never asserted in the same cycle.
- Back-to-back frames need no idle gap beyond the PS/2 stop bit.

Decomposition:
- Shared package/constants: PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, plus the game keycodes consumed by the datapath (enter 8'h5A, colour keys such as 8'h1D).
- One natural sub-module: ps2_rx_frame. It contains the synchronizers, filter, frame FSM and timeout, and outputs byte[7:0], byte_valid and frame_err.
- The top level performs prefix decoding and drives the registered outputs.

Test Plan:
Bench settings: 10 ns clk, FILTER_LEN 8, TIMEOUT_CYCLES 2000, PS/2 bit half-period 200 clk.
1. Frame 0x1D with parity bit 1 and stop bit 1 -> exactly one keycode_ready pulse; keycode=8'h1D, make=1, extended=0; err stays 0.
2. Frames F0 then 1D -> no strobe after F0; one strobe after 1D with keycode=8'h1D, make=0, extended=0.
3. Frames E0, F0, 75 -> single strobe with keycode=8'h75, make=0, extended=1. A following frame 5A -> keycode=8'h5A, make=1, extended=0 (flags cleared).
4. Frame 5A with parity bit 0 (bad) -> one err pulse, no keycode_ready, keycode keeps its prior value. A following good 5A frame decodes normally.
5. Start plus 4 data bits, then ps2_clk held high -> err pulse 2000 (+1) clk after the last fall; FSM in IDLE. A following full 1D frame decodes correctly.
6. Two cases:
   - 3-clk low glitch on ps2_clk mid-frame -> no extra bit counted; the frame decodes correctly.
   - reset pulsed after bit 5 -> all outputs 0, no err. The next full frame decodes correctly.
